// File: rtl/arbiter.sv
// rtl/arbiter.sv - independent round-robin arbiters for the read and write channels
module arbiter #(
  parameter int NUM_CLIENTS           = 8,
  parameter int ADDR_SIZE             = 16,
  parameter int WRITE_DATA_SIZE       = 32,
  parameter int READ_DATA_SIZE        = 512,
  parameter bit HAVE_UPSTREAM_ARBITER = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_CLIENTS-1:0]     client_read_en,
  input  logic [ADDR_SIZE-1:0]       client_read_addr [NUM_CLIENTS],
  input  logic [NUM_CLIENTS-1:0]     client_write_en,
  input  logic [ADDR_SIZE-1:0]       client_write_addr [NUM_CLIENTS],
  input  logic [WRITE_DATA_SIZE-1:0] client_write_data [NUM_CLIENTS],
  input  logic [READ_DATA_SIZE-1:0]  mem_read_data,
  input  logic                       upstream_read_valid,
  input  logic                       upstream_write_done,
  output logic [READ_DATA_SIZE-1:0]  client_read_data,
  output logic [NUM_CLIENTS-1:0]     client_read_valid,
  output logic [NUM_CLIENTS-1:0]     client_write_done,
  output logic                       mem_read_en,
  output logic [ADDR_SIZE-1:0]       mem_read_addr,
  output logic                       mem_write_en,
  output logic [ADDR_SIZE-1:0]       mem_write_addr,
  output logic [WRITE_DATA_SIZE-1:0] mem_write_data,
  output logic [NUM_CLIENTS-1:0]     client_read_grants,
  output logic [NUM_CLIENTS-1:0]     client_write_grants
);

  localparam int PW = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;

  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_idx, wr_idx;
  logic          rd_cmpl, wr_cmpl;

  // First requester at or above the pointer, wrapping; the pointer only moves on
  // completion, so an outstanding grant stays put while its request is held.
  function automatic logic [NUM_CLIENTS-1:0] rr_pick(input logic [NUM_CLIENTS-1:0] req,
                                                     input logic [PW-1:0] ptr);
    logic [NUM_CLIENTS-1:0] g;
    logic                   found;
    logic [PW-1:0]          idx;
    g     = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      idx = PW'((int'(ptr) + i) % NUM_CLIENTS);
      if (!found && req[idx]) begin
        g[idx] = 1'b1;
        found  = 1'b1;
      end
    end
    return g;
  endfunction

  function automatic logic [PW-1:0] onehot_idx(input logic [NUM_CLIENTS-1:0] g);
    logic [PW-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      if (g[i]) idx = PW'(i);
    end
    return idx;
  endfunction

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] idx);
    return PW'((int'(idx) + 1) % NUM_CLIENTS);
  endfunction

  assign rd_cmpl = HAVE_UPSTREAM_ARBITER ? upstream_read_valid : 1'b1;
  assign wr_cmpl = HAVE_UPSTREAM_ARBITER ? upstream_write_done : 1'b1;

  assign client_read_grants  = rr_pick(client_read_en, rd_ptr_q);
  assign client_write_grants = rr_pick(client_write_en, wr_ptr_q);
  assign rd_idx = onehot_idx(client_read_grants);
  assign wr_idx = onehot_idx(client_write_grants);

  always_comb begin
    mem_read_addr  = '0;
    mem_write_addr = '0;
    mem_write_data = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      mem_read_addr  = mem_read_addr  | (client_read_addr[i]  & {ADDR_SIZE{client_read_grants[i]}});
      mem_write_addr = mem_write_addr | (client_write_addr[i] & {ADDR_SIZE{client_write_grants[i]}});
      mem_write_data = mem_write_data | (client_write_data[i] & {WRITE_DATA_SIZE{client_write_grants[i]}});
    end
  end

  assign mem_read_en       = |client_read_grants;
  assign mem_write_en      = |client_write_grants;
  assign client_read_data  = mem_read_en ? mem_read_data : '0;
  assign client_read_valid = client_read_grants & {NUM_CLIENTS{rd_cmpl}};
  assign client_write_done = client_write_grants & {NUM_CLIENTS{wr_cmpl}};

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (mem_read_en && rd_cmpl)  rd_ptr_d = next_ptr(rd_idx);
    if (mem_write_en && wr_cmpl) wr_ptr_d = next_ptr(wr_idx);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

endmodule

// File: tb/tb_arbiter.sv
// tb/tb_arbiter.sv - directed checks of arbiter with and without upstream completion
module tb_arbiter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [7:0]   read_en, write_en, w0_en, zero_en;
  logic [15:0]  r_addr [8];
  logic [15:0]  w_addr [8];
  logic [31:0]  w_data [8];
  logic [511:0] mem_rd;
  logic         up_valid, up_done;

  logic [511:0] rd_data, rd_data0;
  logic [7:0]   rd_valid, wr_done, rgnt, wgnt, rd_valid0, wr_done0, rgnt0, wgnt0;
  logic         mre, mwe, mre0, mwe0;
  logic [15:0]  mra, mwa, mra0, mwa0;
  logic [31:0]  mwd, mwd0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  arbiter #(.HAVE_UPSTREAM_ARBITER(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .client_read_en(read_en), .client_read_addr(r_addr),
    .client_write_en(write_en), .client_write_addr(w_addr), .client_write_data(w_data),
    .mem_read_data(mem_rd), .upstream_read_valid(up_valid), .upstream_write_done(up_done),
    .client_read_data(rd_data), .client_read_valid(rd_valid), .client_write_done(wr_done),
    .mem_read_en(mre), .mem_read_addr(mra),
    .mem_write_en(mwe), .mem_write_addr(mwa), .mem_write_data(mwd),
    .client_read_grants(rgnt), .client_write_grants(wgnt)
  );

  arbiter #(.HAVE_UPSTREAM_ARBITER(0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .client_read_en(zero_en), .client_read_addr(r_addr),
    .client_write_en(w0_en), .client_write_addr(w_addr), .client_write_data(w_data),
    .mem_read_data(mem_rd), .upstream_read_valid(up_valid), .upstream_write_done(up_done),
    .client_read_data(rd_data0), .client_read_valid(rd_valid0), .client_write_done(wr_done0),
    .mem_read_en(mre0), .mem_read_addr(mra0),
    .mem_write_en(mwe0), .mem_write_addr(mwa0), .mem_write_data(mwd0),
    .client_read_grants(rgnt0), .client_write_grants(wgnt0)
  );

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst_n = 1'b0; read_en = '0; write_en = '0; w0_en = '0; zero_en = '0;
    up_valid = 1'b0; up_done = 1'b0;
    mem_rd = {16{32'hCAFE_5A5A}};
    for (int i = 0; i < 8; i++) begin
      r_addr[i] = 16'h1000 + 16'(i);
      w_addr[i] = 16'hA000 + 16'(i);
      w_data[i] = 32'hD000_0000 + 32'(i);
    end
    r_addr[0] = 16'h7A34;
    tick(); tick();
    chk("reset_rd_data", rd_data, '0);
    chk("reset_outs", 512'({rd_valid, wr_done, rgnt, wgnt, mre, mwe, mra, mwa, mwd}), '0);
    chk("reset_outs0", 512'({wr_done0, wgnt0, mwe0, mwa0, mwd0}), '0);
    @(negedge clk); rst_n = 1'b1;
    tick();

    // Single reader, completion withheld
    read_en = 8'h01; #1;
    chk("rd_en", 512'(mre), 512'(1'b1));
    chk("rd_addr", 512'(mra), 512'(16'h7A34));
    chk("rd_data", rd_data, mem_rd);
    chk("rd_valid_wait", 512'(rd_valid), 512'(8'h00));
    tick();
    read_en = 8'h07; #1;
    chk("rd_hold_gnt", 512'(rgnt), 512'(8'h01));
    tick();
    chk("rd_hold_gnt2", 512'(rgnt), 512'(8'h01));
    up_valid = 1'b1; #1;
    chk("rd_valid0", 512'(rd_valid), 512'(8'h01));
    tick();
    chk("rd_gnt1", 512'(rgnt), 512'(8'h02));
    chk("rd_addr1", 512'(mra), 512'(16'h1001));
    chk("rd_valid1", 512'(rd_valid), 512'(8'h02));
    tick();
    chk("rd_gnt2", 512'(rgnt), 512'(8'h04));
    tick();
    chk("rd_gnt_wrap", 512'(rgnt), 512'(8'h01));
    tick();
    chk("rd_gnt1b", 512'(rgnt), 512'(8'h02));
    read_en = 8'h05; #1;
    chk("rd_drop_gnt", 512'(rgnt), 512'(8'h04));
    chk("rd_drop_addr", 512'(mra), 512'(16'h1002));
    read_en = 8'h00; up_valid = 1'b0; #1;
    chk("rd_idle_data", rd_data, '0);
    chk("rd_idle_valid", 512'({rd_valid, mre, mra}), '0);

    // Write channel: clients 0,1,2,7
    write_en = 8'h87; #1;
    chk("wr_gnt0", 512'(wgnt), 512'(8'h01));
    chk("wr_addr0", 512'({mwe, mwa, mwd}), 512'({1'b1, 16'hA000, 32'hD000_0000}));
    chk("wr_done_wait", 512'(wr_done), 512'(8'h00));
    tick();
    chk("wr_hold0", 512'(wgnt), 512'(8'h01));
    up_done = 1'b1; #1;
    chk("wr_done0", 512'(wr_done), 512'(8'h01));
    tick();
    up_done = 1'b0; #1;
    chk("wr_gnt1", 512'({wgnt, mwa, mwd}), 512'({8'h02, 16'hA001, 32'hD000_0001}));
    tick();
    chk("wr_hold1", 512'({wgnt, wr_done}), 512'({8'h02, 8'h00}));
    up_done = 1'b1; #1;
    chk("wr_done1", 512'(wr_done), 512'(8'h02));
    tick();
    chk("wr_gnt2", 512'({wgnt, mwa}), 512'({8'h04, 16'hA002}));
    tick();
    chk("wr_gnt7", 512'({wgnt, mwa, mwd}), 512'({8'h80, 16'hA007, 32'hD000_0007}));
    tick();
    chk("wr_gnt_wrap", 512'(wgnt), 512'(8'h01));
    write_en = 8'h00; up_done = 1'b0; #1;
    chk("wr_idle", 512'({wr_done, mwe, mwa, mwd}), '0);

    // No upstream: one-cycle completion, upstream inputs ignored
    w0_en = 8'h2A; up_done = 1'b0; #1;
    chk("nu_gnt1", 512'({wgnt0, wr_done0, mwa0}), 512'({8'h02, 8'h02, 16'hA001}));
    tick();
    chk("nu_gnt3", 512'({wgnt0, wr_done0, mwd0}), 512'({8'h08, 8'h08, 32'hD000_0003}));
    tick();
    chk("nu_gnt5", 512'({wgnt0, wr_done0}), 512'({8'h20, 8'h20}));
    tick();
    chk("nu_wrap", 512'({wgnt0, wr_done0}), 512'({8'h02, 8'h02}));
    chk("nu_read_idle", 512'({rd_valid0, mre0}), '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
